operand_fetch_stage: RTL and testbench

- ID/EX operand-fetch stage sitting directly upstream of the execute stage.
- Drives the register file's two async read addresses and selects each operand from one of four sources: EX, MEM or WB bypass, or the register file read data.
- Detects load-use hazards, inserts bubbles, and registers the selected operands into the ID/EX pipeline register.
- Keeps a saturating count of load-use stall cycles.

---
 rtl/operand_fetch_stage.sv | 124 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage (ID/EX). It drives the register file read addresses and
// picks each operand from the EX, MEM or WB bypass or from the register file.
// It also detects load-use hazards, inserts bubbles, and counts load-use stall
// cycles in a saturating counter.
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs,
  input  logic [ADDR_WIDTH-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [ADDR_WIDTH-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  output logic [ADDR_WIDTH-1:0] rf_r_address1,
  output logic [ADDR_WIDTH-1:0] rf_r_address2,
  input  logic [DATA_WIDTH-1:0] rf_data1,
  input  logic [DATA_WIDTH-1:0] rf_data2,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  mem_reg_write,
  input  logic [ADDR_WIDTH-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ex_hold,
  input  logic                  flush,
  output logic                  stall_out,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_op_a,
  output logic [DATA_WIDTH-1:0] o_op_b,
  output logic [ADDR_WIDTH-1:0] o_dest,
  output logic                  o_reg_write,
  output logic                  o_mem_read,
  output logic [31:0]           stall_count
);

  logic                  ex_fwd_ok;
  logic                  load_use;
  logic                  rs_hit;
  logic                  rt_hit;
  logic [DATA_WIDTH-1:0] op_a_sel;
  logic [DATA_WIDTH-1:0] op_b_sel;

  assign rf_r_address1 = id_rs;
  assign rf_r_address2 = id_rt;

  // Only an ALU result in EX can be forwarded; a load's data is not ready yet.
  assign ex_fwd_ok = o_valid & o_reg_write & ~o_mem_read;

  // Bypass priority: youngest producer first, register 0 always reads as 0.
  function automatic logic [DATA_WIDTH-1:0] pick_operand(
    input logic [ADDR_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0] rf_val
  );
    logic [DATA_WIDTH-1:0] result;
    if (src == '0)
      result = '0;
    else if (ex_fwd_ok && (o_dest == src))
      result = ex_result;
    else if (mem_reg_write && (mem_dest == src))
      result = mem_result;
    else if (wb_reg_write && (wb_dest == src))
      result = wb_data;
    else
      result = rf_val;
    return result;
  endfunction

  // Operand selection for both sources.
  always_comb begin
    op_a_sel = pick_operand(id_rs, rf_data1);
    op_b_sel = pick_operand(id_rt, rf_data2);
  end

  // A load in EX whose destination a decode source needs forces one bubble.
  assign rs_hit   = id_uses_rs & (id_rs == o_dest);
  assign rt_hit   = id_uses_rt & (id_rt == o_dest);
  assign load_use = id_valid & o_valid & o_mem_read & o_reg_write &
                    (o_dest != '0) & (rs_hit | rt_hit);

  assign stall_out = load_use | ex_hold;

  // ID/EX pipeline register: flush, then hold, then load-use bubble, then load.
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      if (!reset_n) begin
        o_valid     <= 1'b0;
        o_op_a      <= '0;
        o_op_b      <= '0;
        o_dest      <= '0;
        o_reg_write <= 1'b0;
        o_mem_read  <= 1'b0;
      end else if (flush || (!ex_hold && load_use)) begin
        o_valid     <= 1'b0;
        o_reg_write <= 1'b0;
        o_mem_read  <= 1'b0;
      end else if (!ex_hold) begin
        o_valid     <= id_valid;
        o_op_a      <= op_a_sel;
        o_op_b      <= op_b_sel;
        o_dest      <= id_dest;
        o_reg_write <= id_valid & id_reg_write;
        o_mem_read  <= id_valid & id_mem_read;
      end
    end
  end

  // Saturating count of load-use stall cycles; flushed cycles are not counted.
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      if (!reset_n)
        stall_count <= '0;
      else if (load_use && !flush && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: a behavioural model of the ID/EX
// register tracks the expected state, a compare process checks it on every
// negative edge, and hand-computed literals pin the key scenarios.
module tb_operand_fetch_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n, clk_enable, id_valid;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic          id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [AW-1:0] rf_r_address1, rf_r_address2;
  logic [DW-1:0] rf_data1, rf_data2, ex_result;
  logic          mem_reg_write;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] mem_result;
  logic          wb_reg_write;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic          ex_hold, flush, stall_out;
  logic          o_valid, o_reg_write, o_mem_read;
  logic [DW-1:0] o_op_a, o_op_b;
  logic [AW-1:0] o_dest;
  logic [31:0]   stall_count;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          valid;
    bit [DW-1:0] a;
    bit [DW-1:0] b;
    bit [AW-1:0] dest;
    bit          rw;
    bit          mr;
  } idex_t;

  idex_t     m;
  bit [31:0] m_count;
  bit        check_en    = 1'b0;
  bit        preload_req = 1'b0;

  operand_fetch_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .rf_r_address1(rf_r_address1), .rf_r_address2(rf_r_address2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .ex_result(ex_result),
    .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_hold(ex_hold), .flush(flush), .stall_out(stall_out),
    .o_valid(o_valid), .o_op_a(o_op_a), .o_op_b(o_op_b), .o_dest(o_dest),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Value a source register must read: newest in-flight writer wins.
  function automatic bit [DW-1:0] model_read(input bit [AW-1:0] r, input bit [DW-1:0] rf_val);
    if (r == 0) return '0;
    if (m.valid && m.rw && !m.mr && m.dest == r) return ex_result;
    if (mem_reg_write && mem_dest == r) return mem_result;
    if (wb_reg_write && wb_dest == r) return wb_data;
    return rf_val;
  endfunction

  function automatic bit model_load_use();
    bit needs;
    needs = (id_uses_rs && id_rs == m.dest) || (id_uses_rt && id_rt == m.dest);
    return id_valid && m.valid && m.mr && m.rw && m.dest != 0 && needs;
  endfunction

  // Model of the ID/EX register and stall counter, advanced on each edge.
  always @(posedge clk) begin
    bit        lu;
    bit [31:0] base;
    idex_t     nxt;
    lu   = model_load_use();
    base = preload_req ? 32'hFFFF_FFFF : m_count;
    nxt  = m;
    if (clk_enable) begin
      if (!reset_n) begin
        nxt     = '{valid: 1'b0, a: '0, b: '0, dest: '0, rw: 1'b0, mr: 1'b0};
        m_count = 0;
      end else begin
        if (flush || (!ex_hold && lu)) begin
          nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0;
        end else if (!ex_hold) begin
          nxt.valid = id_valid;
          nxt.a     = model_read(id_rs, rf_data1);
          nxt.b     = model_read(id_rt, rf_data2);
          nxt.dest  = id_dest;
          nxt.rw    = id_valid && id_reg_write;
          nxt.mr    = id_valid && id_mem_read;
        end
        m_count = (lu && !flush && base != 32'hFFFF_FFFF) ? base + 1 : base;
      end
    end else begin
      m_count = base;
    end
    m = nxt;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("model.o_valid", {31'b0, o_valid}, {31'b0, m.valid});
      check_output("model.o_reg_write", {31'b0, o_reg_write}, {31'b0, m.rw});
      check_output("model.o_mem_read", {31'b0, o_mem_read}, {31'b0, m.mr});
      check_output("model.stall_count", stall_count, preload_req ? 32'hFFFF_FFFF : m_count);
      check_output("model.stall_out", {31'b0, stall_out}, {31'b0, model_load_use() || ex_hold});
      check_output("model.rf_addr1", {27'b0, rf_r_address1}, {27'b0, id_rs});
      check_output("model.rf_addr2", {27'b0, rf_r_address2}, {27'b0, id_rt});
      if (m.valid) begin
        check_output("model.o_op_a", o_op_a, m.a);
        check_output("model.o_op_b", o_op_b, m.b);
        check_output("model.o_dest", {27'b0, o_dest}, {27'b0, m.dest});
      end
    end
  end

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    clk_enable = 1'b1; id_valid = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    rf_data1 = '0; rf_data2 = '0; ex_result = '0;
    mem_reg_write = 1'b0; mem_dest = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_dest = '0; wb_data = '0;
    ex_hold = 1'b0; flush = 1'b0;
  endtask

  task automatic set_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic [AW-1:0] dest, input logic is_load);
    id_valid = 1'b1; id_rs = rs; id_rt = rt;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    id_dest = dest; id_reg_write = 1'b1; id_mem_read = is_load;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    apply_stimulus();
    check_en = 1'b1;
    apply_stimulus();
    check_output("reset.o_valid", {31'b0, o_valid}, 32'd0);
    check_output("reset.stall_count", stall_count, 32'd0);
    check_output("reset.o_op_a", o_op_a, 32'd0);
    reset_n = 1'b1;

    // Plain ADD with no bypass
    set_instr(5'd3, 5'd4, 5'd10, 1'b0);
    rf_data1 = 32'd5; rf_data2 = 32'd7;
    apply_stimulus();
    check_output("add.o_valid", {31'b0, o_valid}, 32'd1);
    check_output("add.o_op_a", o_op_a, 32'd5);
    check_output("add.o_op_b", o_op_b, 32'd7);
    check_output("add.stall_count", stall_count, 32'd0);

    // EX beats MEM
    set_instr(5'd1, 5'd2, 5'd3, 1'b0);
    apply_stimulus();
    set_instr(5'd3, 5'd5, 5'd0, 1'b0);
    ex_result = 32'h11; mem_reg_write = 1'b1; mem_dest = 5'd3; mem_result = 32'h22;
    rf_data1 = 32'h99; rf_data2 = 32'h44;
    apply_stimulus();
    check_output("exfwd.o_op_a", o_op_a, 32'h11);
    check_output("exfwd.o_op_b", o_op_b, 32'h44);

    // Register 0 never forwarded, even with o_dest = 0 and mem_dest = 0
    set_instr(5'd0, 5'd5, 5'd0, 1'b0);
    mem_dest = 5'd0; rf_data1 = 32'h77;
    apply_stimulus();
    check_output("r0.o_op_a", o_op_a, 32'h0);

    // MEM bypass alone
    set_instr(5'd6, 5'd5, 5'd7, 1'b0);
    mem_dest = 5'd6; mem_result = 32'h66;
    apply_stimulus();
    check_output("memfwd.o_op_a", o_op_a, 32'h66);

    // WB bypass over a stale register file value
    set_instr(5'd1, 5'd9, 5'd14, 1'b0);
    mem_reg_write = 1'b0;
    wb_reg_write = 1'b1; wb_dest = 5'd9; wb_data = 32'hABCD;
    rf_data1 = 32'h101; rf_data2 = 32'h0;
    apply_stimulus();
    check_output("wbfwd.o_op_b", o_op_b, 32'hABCD);
    check_output("wbfwd.o_op_a", o_op_a, 32'h101);
    wb_reg_write = 1'b0;

    // Load-use: exactly one bubble, then the operand comes from MEM
    set_instr(5'd1, 5'd2, 5'd8, 1'b1);
    apply_stimulus();
    set_instr(5'd2, 5'd8, 5'd11, 1'b0);
    rf_data2 = 32'hDEAD;
    #1;
    check_output("lu.stall_out", {31'b0, stall_out}, 32'd1);
    apply_stimulus();
    check_output("lu.bubble", {31'b0, o_valid}, 32'd0);
    check_output("lu.stall_count", stall_count, 32'd1);
    check_output("lu.stall_released", {31'b0, stall_out}, 32'd0);
    mem_reg_write = 1'b1; mem_dest = 5'd8; mem_result = 32'h55;
    apply_stimulus();
    check_output("lu.o_valid", {31'b0, o_valid}, 32'd1);
    check_output("lu.o_op_b", o_op_b, 32'h55);
    mem_reg_write = 1'b0;

    // ex_hold freezes the register for three cycles
    set_instr(5'd11, 5'd4, 5'd13, 1'b0);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      check_output("hold.o_op_b", o_op_b, 32'h55);
      check_output("hold.o_dest", {27'b0, o_dest}, 32'd11);
      check_output("hold.stall_out", {31'b0, stall_out}, 32'd1);
      check_output("hold.stall_count", stall_count, 32'd1);
    end
    flush = 1'b1;
    apply_stimulus();
    check_output("flushhold.o_valid", {31'b0, o_valid}, 32'd0);
    flush = 1'b0; ex_hold = 1'b0;

    // clk_enable low during a load-use: nothing moves
    set_instr(5'd1, 5'd2, 5'd12, 1'b1);
    apply_stimulus();
    set_instr(5'd12, 5'd3, 5'd15, 1'b0);
    clk_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus();
      check_output("ce.o_valid", {31'b0, o_valid}, 32'd1);
      check_output("ce.o_dest", {27'b0, o_dest}, 32'd12);
      check_output("ce.stall_count", stall_count, 32'd1);
    end
    clk_enable = 1'b1;
    apply_stimulus();
    check_output("ce.resume_bubble", {31'b0, o_valid}, 32'd0);
    check_output("ce.resume_count", stall_count, 32'd2);

    // Saturation of the stall counter
    set_instr(5'd1, 5'd2, 5'd8, 1'b1);
    apply_stimulus();
    force dut.stall_count = 32'hFFFF_FFFF;
    preload_req = 1'b1;
    #2;
    release dut.stall_count;
    set_instr(5'd3, 5'd8, 5'd16, 1'b0);
    apply_stimulus();
    preload_req = 1'b0;
    check_output("sat.stall_count", stall_count, 32'hFFFF_FFFF);
    check_output("sat.bubble", {31'b0, o_valid}, 32'd0);

    // id_valid low loads a bubble
    set_instr(5'd3, 5'd4, 5'd17, 1'b0);
    id_valid = 1'b0;
    apply_stimulus();
    check_output("idle.o_valid", {31'b0, o_valid}, 32'd0);
    check_output("idle.o_reg_write", {31'b0, o_reg_write}, 32'd0);

    // Reset in the middle of a hold
    set_instr(5'd3, 5'd4, 5'd18, 1'b0);
    apply_stimulus();
    ex_hold = 1'b1; reset_n = 1'b0;
    apply_stimulus();
    check_output("rsthold.o_valid", {31'b0, o_valid}, 32'd0);
    check_output("rsthold.stall_count", stall_count, 32'd0);
    check_output("rsthold.stall_out", {31'b0, stall_out}, 32'd1);
    ex_hold = 1'b0;
    #1;
    check_output("rsthold.stall_clear", {31'b0, stall_out}, 32'd0);
    reset_n = 1'b1;
    apply_stimulus();
    apply_stimulus();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
